// File: rtl/data_sram_responder.sv
// Single-port data RAM answering the CPU data SRAM interface. It has byte-lane
// writes, read-before-write, an address window check and saturating access counters.
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c80_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic [31:0] oob_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0]       mem_q [Depth];
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_cnt_q, load_cnt_d;
  logic [31:0]       store_cnt_q, store_cnt_d;
  logic [31:0]       oob_cnt_q, oob_cnt_d;
  logic              hit;
  logic              is_write;
  logic [ADDR_W-1:0] idx;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign hit      = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign idx      = data_sram_addr[ADDR_W+1:2];
  assign is_write = (data_sram_we != 4'h0);

  // Next-state for read data and counters; holds everything while idle.
  always_comb begin
    rdata_d     = rdata_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    oob_cnt_d   = oob_cnt_q;
    if (data_sram_en) begin
      if (hit) begin
        // A write also returns the word as it was before the write.
        rdata_d = mem_q[idx];
        if (is_write) begin
          store_cnt_d = sat_inc(store_cnt_q);
        end else begin
          load_cnt_d = sat_inc(load_cnt_q);
        end
      end else begin
        rdata_d   = 32'h0;
        oob_cnt_d = sat_inc(oob_cnt_q);
      end
    end
  end

  // Read data and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q     <= 32'h0;
      load_cnt_q  <= 32'h0;
      store_cnt_q <= 32'h0;
      oob_cnt_q   <= 32'h0;
    end else begin
      rdata_q     <= rdata_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
      oob_cnt_q   <= oob_cnt_d;
    end
  end

  // Byte-lane array write. The array itself is never cleared. Tying the reset
  // into this block blocks any write while reset is asserted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Contents are kept across reset.
    end else if (data_sram_en && hit && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign load_cnt        = load_cnt_q;
  assign store_cnt       = store_cnt_q;
  assign oob_cnt         = oob_cnt_q;

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Single-port synchronous data RAM that answers the CPU's data SRAM interface: the device that consumes the load/store requests issued by the EX stage and returns `data_sram_rdata` one cycle later to the MEM stage. It implements byte-lane writes, read-before-write semantics, an address window check, and saturating access counters for bring-up and performance debug. It sits outside the pipeline, at the top level beside the instruction SRAM, and is used in simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_W`, 14: word-address width; depth = 2^ADDR_W 32-bit words (64 KiB).
- `BASE_ADDR`, 32'h1c80_0000: byte base of the window; must be aligned to 2^(ADDR_W+2).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_we`  in  4  byte-lane write enables; 4'h0 means a read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data, already lane-shifted by the requester.
- `data_sram_rdata`  out  32  registered read data.
- `load_cnt`  out  32  accepted in-window reads (saturating).
- `store_cnt`  out  32  accepted in-window writes (saturating).
- `oob_cnt`  out  32  requests outside the window (saturating).

## Operation
- Window hit: `hit = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2])`; word index = `data_sram_addr[ADDR_W+1:2]`.
- Request accepted when `resetn` is high and `data_sram_en` = 1. There is no backpressure; every request completes in one cycle.
- Accepted hit, `we` = 0: `rdata` <= mem[idx]; `load_cnt` += 1.
- Accepted hit, `we` != 0: for each i with `we[i]` = 1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]; other lanes are unchanged. `rdata` <= the pre-write word (read-before-write); `store_cnt` += 1.
- Accepted miss, any `we`: no array write; `rdata` <= 32'h0; `oob_cnt` += 1. `load_cnt` and `store_cnt` are unchanged.
- `data_sram_en` = 0: `rdata` holds its previous value; the array and counters are unchanged.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Array contents are not reset and are not initialised. A read of a never-written word returns X in simulation; benches must write before they read.
- No lane-extension or alignment logic exists here. Sign/zero extension and byte shifting belong to the MEM stage.

## Timing
- Read latency is 1 cycle: a request sampled at edge N presents data on `rdata` after edge N and holds it until the next accepted request.
- Back-to-back requests are allowed every cycle. A read at N+1 of the word written at N returns the new data.
- Same-cycle read and write of one word cannot occur (single port). A write's `rdata` is the old word.
- Reset values: `data_sram_rdata` = 0, `load_cnt` = 0, `store_cnt` = 0, `oob_cnt` = 0. These are applied immediately on `resetn` falling, with no clock needed.
- While `resetn` = 0, all requests are ignored and no array write occurs, including a write already presented in the cycle reset asserts.
- The first request is accepted on the first rising edge with `resetn` = 1.
- Counter increment and `rdata` update occur on the same edge as the array write.

## Test plan
- Full-word write/read: write 32'hDEAD_BEEF with `we`=4'hF to 0x1c80_0010, then read the same address → `rdata` = 32'hDEAD_BEEF one cycle after the read; `store_cnt` = 1, `load_cnt` = 1.
- Byte lanes: preload 32'h1122_3344 at 0x1c80_0020, then write 32'h00AA_0000 with `we`=4'h4 → a read returns 32'h11AA_3344. The write's own `rdata` = 32'h1122_3344.
- Out of window: read 0x1c81_0000 and write 32'hFFFF_FFFF to 0x0000_0000 → `rdata` = 0 after each; no array change (re-read of 0x1c80_0000 is unchanged); `oob_cnt` = 2.
- Idle hold: read returns 32'hCAFE_0001, then deassert `data_sram_en` for 5 cycles while toggling addr/we/wdata → `rdata` stays 32'hCAFE_0001; the array and counters are unchanged.
- Async reset mid-stream: assert `resetn`=0 between edges during a write burst → `rdata` and all counters read 0 before the next edge; the word targeted on the reset cycle keeps its old value.
- Saturation: force `load_cnt` to 32'hFFFF_FFFE, then issue 3 reads → `load_cnt` = 32'hFFFF_FFFF, with no wrap.
